// File: rtl/d_merge_logic_pkg.sv
// Shared definitions for the transmission-layer full/merge logic pair:
// state encoding, default widths and the threshold helper.
package d_merge_logic_pkg;

    localparam int DATA_WIDTH_DEF    = 6;
    localparam int ADDRESS_WIDTH_DEF = 2;

    // A zero threshold means "use the downstream depth".
    localparam logic [3:0] UMBRAL_DEF = 4'd0;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // True when the programmed threshold cannot be used as-is and the
    // downstream depth must stand in for it.
    function automatic bit threshold_uses_depth(input logic [3:0] umbral,
                                                input int unsigned depth);
        return (umbral == 4'd0) || ({28'd0, umbral} > depth);
    endfunction

endpackage

// File: rtl/d_merge_logic_rr_arbiter2.sv
// Two-input round-robin grant. The pointer only moves when both inputs
// compete, so a lone requester never steals the other side's next turn.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;   // 0: input 0 wins a tie, 1: input 1 wins a tie

    // Grant one requester when enabled; ties resolved by the pointer.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Hand priority to the loser after every contested grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (en && (req == 2'b11)) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/d_merge_logic.sv
// Egress merge: drains destination FIFOs D0/D1 into one stream, gated by
// a credit counter that mirrors the downstream output FIFO occupancy.
//
// state  | meaning
// RESET  | first cycle after reset, nothing running
// INIT   | threshold being (re)loaded, no pops
// IDLE   | sources empty or no credit to start
// ACTIVE | arbitrating and popping sources
// ERROR  | credit underflow/overflow seen, sticky until reset
module d_merge_logic
    import d_merge_logic_pkg::*;
#(
    parameter int data_width    = DATA_WIDTH_DEF,
    parameter int address_width = ADDRESS_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic [3:0]             umbral_Ds,
    input  logic                   empty_D0,
    input  logic                   empty_D1,
    input  logic [data_width-1:0]  data_D0,
    input  logic [data_width-1:0]  data_D1,
    input  logic                   out_pop,
    output logic                   D0_pop,
    output logic                   D1_pop,
    output logic [data_width-1:0]  data_out,
    output logic                   valid_out,
    output logic [address_width:0] credit_cnt,
    output logic                   idle_out,
    output logic                   active_out,
    output logic                   error_out
);

    localparam int unsigned             DEPTH   = 2 ** address_width;
    localparam logic [address_width:0]  DEPTH_C = (address_width + 1)'(DEPTH);
    localparam logic [address_width:0]  ONE_C   = (address_width + 1)'(1);

    state_t                 state_q, state_n;
    logic [3:0]             umbral_q;
    logic [address_width:0] limit;
    logic                   credit_ok;
    logic                   pop_en;
    logic [1:0]             req, gnt;
    logic                   pop_any;
    logic                   underflow, overflow, err_now;
    logic                   src_sel_q;   // source of the word now on data_out

    // Effective threshold: the latched value, or the depth when it is unusable.
    always_comb begin
        limit = DEPTH_C;
        if (!threshold_uses_depth(umbral_q, DEPTH)) begin
            limit = (address_width + 1)'(umbral_q);
        end
    end

    assign credit_ok = (credit_cnt < limit);
    assign req       = {~empty_D1, ~empty_D0};

    // Pops are combinational so the empty flags are never over-run; reset and
    // init cut them off in the very cycle they are raised.
    assign pop_en = (state_q == ST_ACTIVE) && !reset && !init && credit_ok;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (pop_en),
        .req   (req),
        .gnt   (gnt)
    );

    assign D0_pop  = gnt[0];
    assign D1_pop  = gnt[1];
    assign pop_any = D0_pop | D1_pop;

    // A pop cancels a simultaneous out_pop, so neither can fault in that case.
    assign underflow = out_pop && !pop_any && (credit_cnt == '0);
    assign overflow  = pop_any && !out_pop && (credit_cnt == DEPTH_C);
    assign err_now   = (state_q != ST_RESET) && (underflow || overflow);

    // Source FIFO data arrives one cycle after the pop, so the output word is
    // selected from the live read data using the registered source select.
    assign data_out = valid_out ? (src_sel_q ? data_D1 : data_D0) : '0;

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_RESET: state_n = ST_INIT;
            ST_INIT: begin
                if (err_now)    state_n = ST_ERROR;
                else if (!init) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (err_now)                      state_n = ST_ERROR;
                else if (init)                    state_n = ST_INIT;
                else if ((|req) && credit_ok)     state_n = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (err_now)                      state_n = ST_ERROR;
                else if (init)                    state_n = ST_INIT;
                else if (!(|req) && !valid_out)   state_n = ST_IDLE;
            end
            ST_ERROR: state_n = ST_ERROR;
            default:  state_n = ST_RESET;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RESET;
        else       state_q <= state_n;
    end

    // Threshold is tracked continuously while in INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            umbral_q <= UMBRAL_DEF;
        end else if (state_q == ST_INIT) begin
            umbral_q <= umbral_Ds;
        end
    end

    // Credit reserved at pop time, released on out_pop; held on any fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_cnt <= '0;
        end else if ((state_q != ST_RESET) && !underflow && !overflow) begin
            if (pop_any && !out_pop)      credit_cnt <= credit_cnt + ONE_C;
            else if (out_pop && !pop_any) credit_cnt <= credit_cnt - ONE_C;
        end
    end

    // Output strobe and source select for the word popped last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            src_sel_q <= 1'b0;
        end else begin
            valid_out <= pop_any;
            if (pop_any) src_sel_q <= D1_pop;
        end
    end

    // Status flags registered from the next state so they match state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            idle_out   <= (state_n == ST_IDLE);
            active_out <= (state_n == ST_ACTIVE);
            error_out  <= (state_n == ST_ERROR);
        end
    end

endmodule

// File: doc/d_merge_logic.md
Name: d_merge_logic

Overview:
- Egress-side counterpart of the transmission-layer full logic. The full logic splits one 6-bit stream into destination FIFOs D0/D1; this block drains D0/D1 and merges them back into one 6-bit stream.
- Round-robin arbitration between D0 and D1, gated by a credit counter that tracks occupancy of the downstream output FIFO against a programmable threshold.
- Reports the same init/idle/active/error status set as the full logic.

Parameters:
- data_width, 6, width of each data word.
- address_width, 2, downstream FIFO address width; downstream depth = 2**address_width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  while high, threshold is (re)loaded and the block sits in INIT.
- umbral_Ds  in  4  downstream almost-full threshold, sampled in INIT.
- empty_D0, empty_D1  in  1 each  source FIFO empty flags.
- data_D0, data_D1  in  data_width each  source FIFO read data, valid 1 cycle after pop.
- out_pop  in  1  downstream consumer removed one word from the output FIFO.
- D0_pop, D1_pop  out  1 each  pop strobes to the source FIFOs.
- data_out  out  data_width  merged word.
- valid_out  out  1  data_out valid; acts as the push strobe for the downstream FIFO.
- credit_cnt  out  address_width+1  current reserved downstream occupancy.
- idle_out, active_out, error_out  out  1 each  state flags.

Behaviour:
- Reset (reset=1 at an edge): state=RESET; all outputs 0; round-robin pointer set to D0; credit_cnt=0; umbral register=0. Reset mid-operation discards any in-flight pop (no valid_out on the following cycle).
- States:
  - RESET -> INIT: first cycle with reset=0.
  - INIT: latch umbral_Ds every cycle; issue no pops. Exit to IDLE when init=0.
  - IDLE: both empties high. Go to ACTIVE when either empty is low and credit is available.
  - ACTIVE: pops are issued. Return to IDLE when both empties are high and no pop is in flight.
  - ERROR: entered from any state except RESET on a credit underflow or overflow. Sticky until reset. No pops issued; valid_out=0.
- Flags: idle_out=1 only in IDLE, active_out=1 only in ACTIVE, error_out=1 only in ERROR. Flags are registered and follow the state.
- Credit available when credit_cnt < umbral (latched value). If the latched umbral is 0 or exceeds the downstream depth, the depth is used instead.
- Arbitration, evaluated each cycle in ACTIVE with credit available:
  - Candidates are the FIFOs with empty=0.
  - One candidate: pop it.
  - Both: pop the one the pointer indicates, then toggle the pointer to the other.
  - At most one pop per cycle; the pop is a 1-cycle pulse.
- Latency: pop at cycle t; data_out = data of the popped FIFO and valid_out=1 at t+1. Back-to-back pops give one word per cycle.
- Credit counter:
  - +1 on each issued pop (reserved at pop time, not at valid_out).
  - -1 on out_pop.
  - Pop and out_pop in the same cycle: net 0.
  - out_pop while credit_cnt=0 (underflow) -> ERROR, counter held.
  - Increment reaching depth+1 (overflow) -> ERROR; unreachable when the threshold logic is correct, but checked anyway.
- Threshold hysteresis: none. Pops stop in the cycle credit_cnt reaches umbral and resume the cycle after an out_pop lowers it.
- init reasserted while in IDLE/ACTIVE:
  - Return to INIT, stop pops, keep credit_cnt.
  - A pop already in flight still produces its valid_out.

Decomposition:
- Shared package (with the full logic):
  - State encoding constants: RESET, INIT, IDLE, ACTIVE, ERROR.
  - Default threshold constant.
  - data_width / address_width defaults.
- One natural sub-module, rr_arbiter2: 2-input round-robin grant with pointer register and enable input.
- Credit counter and FSM stay in the top module.

Test Plan:
- Reset then init: reset=1 for 2 cycles, init=1 with umbral_Ds=2, then init=0 -> outputs all 0 during reset; INIT then IDLE; idle_out=1; latched umbral=2.
- Single source: D0 holds 3 words (5,4,6), D1 empty, out_pop=0, umbral=4 -> D0_pop on 3 consecutive cycles; data_out 5,4,6 one cycle later; credit_cnt ends at 3; return to IDLE.
- Fairness: both FIFOs non-empty with 4 words each, umbral=4, out_pop=1 every cycle -> pops alternate D0,D1,D0,D1...; credit_cnt stays ≤1.
- Threshold stall: umbral=2, D0 full, out_pop=0 -> exactly 2 pops, then stall. Pulse out_pop once -> exactly one more pop on the next cycle.
- Underflow: out_pop=1 while credit_cnt=0 -> next cycle error_out=1, pops stop. Stays in ERROR until reset=1.
- Reset mid-stream: reset asserted the cycle after a D1_pop -> no valid_out follows; credit_cnt=0; state RESET.
